// File: rtl/io_tx_buffer.sv
// io_tx_buffer: byte FIFO between a memory-mapped CPU port and a UART transmitter.
// Latency: a byte written at edge N is visible on tx_data/tx_valid after edge N.
// Backpressure: io_buffer_full warns the CPU early; writes into a full FIFO are dropped and flagged.
//
// Ports:
//   clk_in, rst_in          clock and synchronous active-high reset
//   rdy_in                  CPU ready; bus writes only count while high
//   mem_a, mem_dout, mem_wr CPU address, write data, write strobe
//                           0x30000 = data byte (0x00 ignored), 0x30004 = stop request
//   io_buffer_full          free slots <= FULL_MARGIN (combinational)
//   tx_data, tx_valid       head byte and non-empty indication toward the UART
//   tx_ready                UART takes the head byte at this edge
//   program_done            sticky: stop requested and FIFO fully drained
//   overflow                sticky: a data byte was dropped because the FIFO was full
//
// Optional feature: define IO_TX_STOP_NUL_EN to append a 0x00 terminator
// after the last data byte when a stop is requested.
module io_tx_buffer #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_CNT = CW'(FULL_MARGIN);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STOP_PEND = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic       bus_sel;
  logic       data_wr;
  logic       stop_wr;
  logic       deq;
  logic       enq;
  logic [7:0] enq_dat;
  logic       is_full;
  logic       unused_addr_bits;

  // Only bits 17:16 and 2 participate in the decode; the rest are don't-care.
  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

  assign bus_sel = mem_wr && rdy_in && (mem_a[17:16] == 2'b11);
  assign data_wr = bus_sel && !mem_a[2];
  assign stop_wr = bus_sel && mem_a[2];

  assign is_full  = (count_q == FULL_CNT);
  assign tx_valid = (count_q != '0);
  assign tx_data  = mem_q[rd_ptr_q];
  // Dequeue is independent of the FSM and of rdy_in so draining never stalls.
  assign deq      = tx_valid && tx_ready;

  assign io_buffer_full = ((FULL_CNT - count_q) <= MARGIN_CNT);
  assign program_done   = (state_q == ST_DONE);
  assign overflow       = ovf_q;

  always_comb begin
    state_d = state_q;
    enq     = 1'b0;
    enq_dat = mem_dout;
    ovf_d   = ovf_q;

    case (state_q)
      ST_RUN: begin
        if (data_wr && (mem_dout != 8'h00)) begin
          // A full FIFO still accepts if the head leaves in the same cycle.
          if (!is_full || deq) begin
            enq = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (stop_wr) begin
`ifdef IO_TX_STOP_NUL_EN
          state_d = ST_STOP_PEND;
`else
          state_d = ST_DRAIN;
`endif
        end
      end
      ST_STOP_PEND: begin
`ifdef IO_TX_STOP_NUL_EN
        // Terminator waits for room rather than being dropped, so it never flags overflow.
        enq_dat = 8'h00;
        if (!is_full || deq) begin
          enq     = 1'b1;
          state_d = ST_DRAIN;
        end
`else
        state_d = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; count gates visibility of stale entries.
  // When full, wr_ptr == rd_ptr: the head is read before this edge overwrites it.
  always_ff @(posedge clk_in) begin
    if (enq && !rst_in) begin
      mem_q[wr_ptr_q] <= enq_dat;
    end
  end

endmodule

// File: tb/tb_io_tx_buffer.sv
// tb_io_tx_buffer: directed self-checking bench for io_tx_buffer (DEPTH 16, margin 2).
// Latency: inputs are driven 1ns after a rising edge and outputs checked 1ns after the next one.
// Backpressure: tx_ready is driven explicitly by every vector and sequence.
module tb_io_tx_buffer;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_done;
  logic        overflow;

  int n_checks;
  int n_fail;

  io_tx_buffer #(
    .DEPTH_LOG2 (4),
    .FULL_MARGIN(2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .program_done  (program_done),
    .overflow      (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_STOP = 32'h0003_0004;
  localparam logic [31:0] A_MISS = 32'h0002_0000;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rdy;
    logic [31:0] addr;
    logic [7:0]  dat;
    logic        txr;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_full;
    logic        e_ovf;
    logic        e_done;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge sample them, then settle.
  task automatic drive(input logic rst, input logic wr, input logic rdy,
                       input logic [31:0] addr, input logic [7:0] dat, input logic txr);
    rst_in   = rst;
    mem_wr   = wr;
    rdy_in   = rdy;
    mem_a    = addr;
    mem_dout = dat;
    tx_ready = txr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input logic txr);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 8'h00, txr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_in   = 1'b1;
    rdy_in   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    tx_ready = 1'b0;

    //            rst  wr   rdy  addr    dat    txr   valid data   full ovf  done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, A_DATA, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, A_DATA, 8'h42, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, A_DATA, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, A_DATA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, A_DATA, 8'h56, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, A_MISS, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, A_DATA, 8'h77, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,  8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rdy, vecs[i].addr, vecs[i].dat, vecs[i].txr);
      chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d full", i), 32'(io_buffer_full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d done", i), 32'(program_done), 32'(vecs[i].e_done));
    end

    // Fill to DEPTH with bytes 1..16; full asserts once 14 are held.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    chk("fill reset overflow", 32'(overflow), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b1, 1'b1, A_DATA, 8'(k), 1'b0);
      chk($sformatf("fill%0d full", k), 32'(io_buffer_full), (k >= 14) ? 32'd1 : 32'd0);
    end
    chk("fill16 overflow", 32'(overflow), 32'd0);
    chk("fill16 head", 32'(tx_data), 32'h01);

    // Enqueue and dequeue together while full: accepted, no overflow.
    drive(1'b0, 1'b1, 1'b1, A_DATA, 8'h99, 1'b1);
    chk("full swap overflow", 32'(overflow), 32'd0);
    chk("full swap still full", 32'(io_buffer_full), 32'd1);
    chk("full swap head", 32'(tx_data), 32'h02);

    // Plain enqueue while full: dropped and flagged.
    drive(1'b0, 1'b1, 1'b1, A_DATA, 8'hAA, 1'b0);
    chk("drop overflow", 32'(overflow), 32'd1);

    // Drain: 2..16 then 0x99; 0xAA must not appear.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d valid", k), 32'(tx_valid), 32'd1);
      chk($sformatf("drain%0d data", k), 32'(tx_data), (k < 15) ? 32'(k + 2) : 32'h99);
      idle(1'b1);
    end
    chk("drain empty", 32'(tx_valid), 32'd0);
    chk("drain overflow sticky", 32'(overflow), 32'd1);

    // Stop request sequence.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, A_DATA, 8'h58, 1'b0);
    chk("stop q58 data", 32'(tx_data), 32'h58);
    drive(1'b0, 1'b1, 1'b1, A_STOP, 8'h00, 1'b0);
    chk("stop req valid", 32'(tx_valid), 32'd1);
    chk("stop req data", 32'(tx_data), 32'h58);
    chk("stop req done", 32'(program_done), 32'd0);
`ifdef IO_TX_STOP_NUL_EN
    idle(1'b1);
    chk("stop nul valid", 32'(tx_valid), 32'd1);
    chk("stop nul data", 32'(tx_data), 32'h00);
    chk("stop nul done", 32'(program_done), 32'd0);
    idle(1'b1);
`else
    idle(1'b1);
`endif
    chk("stop empty valid", 32'(tx_valid), 32'd0);
    chk("stop empty done", 32'(program_done), 32'd0);
    idle(1'b1);
    chk("stop done", 32'(program_done), 32'd1);
    drive(1'b0, 1'b1, 1'b1, A_DATA, 8'h33, 1'b0);
    chk("done ignores data", 32'(tx_valid), 32'd0);
    chk("done sticky", 32'(program_done), 32'd1);
    chk("stop overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a drain.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    chk("rst leaves done", 32'(program_done), 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b1, A_DATA, 8'(8'h21 + k), 1'b0);
    drive(1'b0, 1'b1, 1'b1, A_STOP, 8'h00, 1'b0);
    idle(1'b1);
    chk("mid-drain head", 32'(tx_data), 32'h22);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 8'h00, 1'b1);
    chk("mid rst valid", 32'(tx_valid), 32'd0);
    chk("mid rst done", 32'(program_done), 32'd0);
    chk("mid rst full", 32'(io_buffer_full), 32'd0);
    drive(1'b0, 1'b1, 1'b1, A_DATA, 8'h5A, 1'b0);
    chk("mid rst RUN valid", 32'(tx_valid), 32'd1);
    chk("mid rst RUN data", 32'(tx_data), 32'h5A);
    idle(1'b0);
    idle(1'b0);
    chk("mid rst no done", 32'(program_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
